// File: rtl/fib_disp_pkg.sv
// Shared types and constants for the Fibonacci display path: FSM encoding,
// active-low 7-segment codes and the double-dabble nibble adjust.
package fib_disp_pkg;

  localparam int DIGITS = 5;
  localparam int BIN_W  = 16;
  localparam int BCD_W  = 4 * DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } conv_state_t;

  // Segment order {a,b,c,d,e,f,g,dp}, active low, dp held off
  localparam logic [7:0] SEG_0     = 8'h03;
  localparam logic [7:0] SEG_1     = 8'h9F;
  localparam logic [7:0] SEG_2     = 8'h25;
  localparam logic [7:0] SEG_3     = 8'h0D;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h49;
  localparam logic [7:0] SEG_6     = 8'h41;
  localparam logic [7:0] SEG_7     = 8'h1F;
  localparam logic [7:0] SEG_8     = 8'h01;
  localparam logic [7:0] SEG_9     = 8'h09;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Pre-shift correction: any BCD nibble >= 5 gets +3 so the shift carries correctly
  function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/fib_display_ctrl_if.sv
// Generator-side term input and board-side display/status outputs.
interface fib_display_ctrl_if;
  import fib_disp_pkg::*;

  logic             f_valid;
  logic [BIN_W-1:0] f_out;
  logic             busy;
  logic [7:0]       an;
  logic [7:0]       dec_ddp;

  modport master (output f_valid, f_out, input busy, an, dec_ddp);
  modport slave  (input f_valid, f_out, output busy, an, dec_ddp);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift per cycle, BIN_W iterations, then a
// single DONE cycle in which bcd_out holds the result.
module bin2bcd_seq
  import fib_disp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd_out
);

  conv_state_t      r_state, w_next;
  logic [BIN_W-1:0] r_bin;
  logic [BCD_W-1:0] r_bcd;
  logic [4:0]       r_iter;
  logic [BCD_W-1:0] w_adj;

  assign w_adj = dabble_adj(r_bcd);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_CONV;
      ST_CONV: if (r_iter == 5'(BIN_W - 1)) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_iter <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (start) begin
          r_bin  <= bin_in;
          r_bcd  <= '0;
          r_iter <= '0;
        end
        ST_CONV: begin
          {r_bcd, r_bin} <= {w_adj[BCD_W-2:0], r_bin, 1'b0};
          r_iter         <= r_iter + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != ST_IDLE);
  assign done    = (r_state == ST_DONE);
  assign bcd_out = r_bcd;

endmodule

// File: rtl/fib_display_ctrl.sv
// Captures Fibonacci terms, converts them to BCD and scans five digits onto
// a multiplexed active-low 7-segment display with leading-zero blanking.
module fib_display_ctrl
  import fib_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  fib_display_ctrl_if.slave bus
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic             w_busy, w_done, w_start;
  logic [BIN_W-1:0] w_bin;
  logic [BCD_W-1:0] w_bcd;

  logic             r_pend_vld;
  logic [BIN_W-1:0] r_pend;
  logic [BCD_W-1:0] r_disp;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic [7:0]       r_an, r_seg;

  // A live sample always beats the pending one; both leave pending empty
  assign w_start = !w_busy && (bus.f_valid || r_pend_vld);
  assign w_bin   = bus.f_valid ? bus.f_out : r_pend;

  bin2bcd_seq u_conv (
    .clk     (clk),
    .rst     (rst),
    .start   (w_start),
    .bin_in  (w_bin),
    .busy    (w_busy),
    .done    (w_done),
    .bcd_out (w_bcd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_vld <= 1'b0;
      r_pend     <= '0;
    end else if (bus.f_valid && w_busy) begin
      r_pend_vld <= 1'b1;
      r_pend     <= bus.f_out;
    end else if (w_start) begin
      r_pend_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         r_disp <= '0;
    else if (w_done) r_disp <= w_bcd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (r_cnt == CNT_W'(REFRESH_DIV - 1)) begin
      r_cnt <= '0;
      r_idx <= (r_idx == 3'(DIGITS - 1)) ? 3'd0 : r_idx + 3'd1;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // w_show[i]: digit i is at or below the most significant nonzero digit
  logic [7:0]  w_show;
  logic [31:0] w_disp_ext;
  logic [3:0]  w_digit;

  assign w_show[7:DIGITS]   = '0;
  assign w_show[DIGITS-1]   = |r_disp[(DIGITS-1)*4 +: 4];
  assign w_show[0]          = 1'b1;
  for (genvar g = 1; g < DIGITS - 1; g++) begin : g_blank
    assign w_show[g] = w_show[g+1] | (|r_disp[g*4 +: 4]);
  end

  assign w_disp_ext = {{(32-BCD_W){1'b0}}, r_disp};
  assign w_digit    = w_disp_ext[{r_idx, 2'b00} +: 4];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_an  <= 8'hFF;
      r_seg <= SEG_BLANK;
    end else begin
      r_an  <= ~(8'h01 << r_idx);
      r_seg <= w_show[r_idx] ? seg_decode(w_digit) : SEG_BLANK;
    end
  end

  assign bus.busy    = w_busy;
  assign bus.an      = r_an;
  assign bus.dec_ddp = r_seg;

endmodule

// File: tb/tb_fib_display_ctrl.sv
// Table-driven bench with a display-value scoreboard for fib_display_ctrl.
module tb_fib_display_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fib_display_ctrl_if bus ();

  fib_display_ctrl #(.REFRESH_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] val;
    logic [39:0] segs;   // {d4,d3,d2,d1,d0}
  } vec_t;

  vec_t        tbl[8];
  logic [39:0] sb_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_term(input logic [15:0] v);
    @(negedge clk);
    bus.f_valid = 1'b1;
    bus.f_out   = v;
    @(negedge clk);
    bus.f_valid = 1'b0;
  endtask

  task automatic wait_busy(input logic lvl, input int lim, input string name);
    int g = 0;
    while (bus.busy !== lvl && g < lim) begin
      @(negedge clk);
      g++;
    end
    chk(name, 32'(bus.busy), 32'(lvl));
  endtask

  task automatic read_digits(input logic [39:0] exp, input string name);
    logic [7:0] an_exp;
    for (int i = 0; i < 5; i++) begin
      int g = 0;
      an_exp = ~(8'h01 << i);
      while (bus.an !== an_exp && g < 40) begin
        @(negedge clk);
        g++;
      end
      chk($sformatf("%s an%0d", name, i), 32'(bus.an), 32'(an_exp));
      chk($sformatf("%s dig%0d", name, i), 32'(bus.dec_ddp), 32'(exp[i*8 +: 8]));
    end
  endtask

  function automatic int an2idx(input logic [7:0] a);
    case (a)
      8'hFE: return 0;
      8'hFD: return 1;
      8'hFB: return 2;
      8'hF7: return 3;
      8'hEF: return 4;
      default: return -1;
    endcase
  endfunction

  task automatic pop_exp(output logic [39:0] e);
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      e = '1;
    end else begin
      e = sb_q.pop_front();
    end
  endtask

  task automatic apply_vec(input int i);
    int          cnt = 0;
    logic [39:0] e;
    sb_q.push_back(tbl[i].segs);
    drive_term(tbl[i].val);
    while (bus.busy === 1'b1 && cnt < 60) begin
      cnt++;
      @(negedge clk);
    end
    chk($sformatf("busy_len v%0d", tbl[i].val), 32'(cnt), 32'd17);
    pop_exp(e);
    read_digits(e, $sformatf("val%0d", tbl[i].val));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [39:0] e;
    logic [7:0]  an_seq[6];
    logic [7:0]  prev_an;
    int          g, busy_hits;

    tbl[0] = '{16'd55,    40'hFFFFFF4949};
    tbl[1] = '{16'd65535, 40'h4149490D49};
    tbl[2] = '{16'd0,     40'hFFFFFFFF03};
    tbl[3] = '{16'd10000, 40'h9F03030303};
    tbl[4] = '{16'd907,   40'hFFFF09031F};
    tbl[5] = '{16'd28657, 40'h250141491F};
    tbl[6] = '{16'd4181,  40'hFF999F019F};
    tbl[7] = '{16'd1,     40'hFFFFFFFF9F};

    bus.f_valid = 1'b0;
    bus.f_out   = '0;

    // Reset held three cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst an", 32'(bus.an), 32'hFF);
    chk("rst dec", 32'(bus.dec_ddp), 32'hFF);
    chk("rst busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst an", 32'(bus.an), 32'hFE);
    chk("post_rst dec", 32'(bus.dec_ddp), 32'h03);
    read_digits(40'hFFFFFFFF03, "post_rst");

    for (int i = 0; i < 8; i++) apply_vec(i);

    // Back-to-back samples while busy: oldest converts, newest waits, middle dropped
    sb_q.push_back(40'hFFFFFF9F0D);
    @(negedge clk);
    bus.f_valid = 1'b1; bus.f_out = 16'd13;
    @(negedge clk);
    bus.f_out = 16'd21;
    @(negedge clk);
    bus.f_out = 16'd34;
    sb_q.push_back(40'hFFFFFF0D99);
    @(negedge clk);
    bus.f_valid = 1'b0;
    wait_busy(1'b0, 40, "pend13_done");
    pop_exp(e);
    @(negedge clk);
    for (int s = 0; s < 14; s++) begin
      @(negedge clk);
      g = an2idx(bus.an);
      chk("pend13 an_valid", 32'(g >= 0), 32'd1);
      if (g >= 0) chk($sformatf("pend13 dig%0d", g), 32'(bus.dec_ddp), 32'(e[g*8 +: 8]));
    end
    wait_busy(1'b0, 40, "pend34_done");
    pop_exp(e);
    read_digits(e, "pend34");
    busy_hits = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.busy) busy_hits++;
    end
    chk("no_third_conv", 32'(busy_hits), 32'd0);

    // Sample arriving in the DONE cycle is converted right after
    drive_term(16'd7);
    repeat (16) @(negedge clk);
    chk("done_cycle busy", 32'(bus.busy), 32'd1);
    bus.f_valid = 1'b1; bus.f_out = 16'd8;
    sb_q.push_back(40'hFFFFFFFF01);
    @(negedge clk);
    bus.f_valid = 1'b0;
    chk("done_cycle idle_gap", 32'(bus.busy), 32'd0);
    wait_busy(1'b1, 4, "done_cycle restart");
    wait_busy(1'b0, 40, "done_cycle finish");
    pop_exp(e);
    read_digits(e, "done_cycle8");

    // Idle scan order and dwell
    an_seq = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hFE};
    prev_an = bus.an;
    g = 0;
    @(negedge clk);
    while (!(prev_an == 8'hEF && bus.an == 8'hFE) && g < 40) begin
      prev_an = bus.an;
      @(negedge clk);
      g++;
    end
    chk("scan_align", 32'(bus.an), 32'hFE);
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("scan k%0d c%0d", k, c), 32'(bus.an), 32'(an_seq[k]));
        @(negedge clk);
      end
    end

    // Reset mid-conversion with a pending sample queued
    drive_term(16'd987);
    repeat (2) @(negedge clk);
    bus.f_valid = 1'b1; bus.f_out = 16'd500;
    @(negedge clk);
    bus.f_valid = 1'b0;
    @(negedge clk);
    chk("midrst pre busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst an", 32'(bus.an), 32'hFF);
    chk("midrst dec", 32'(bus.dec_ddp), 32'hFF);
    chk("midrst busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    busy_hits = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.busy) busy_hits++;
    end
    chk("midrst pending_empty", 32'(busy_hits), 32'd0);
    read_digits(40'hFFFFFFFF03, "midrst zero");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
